// File: rtl/calc_entry_ctrl_pkg.sv
// calc_pkg: shared states, key classes, display codes and scan-code table for calc_entry_ctrl.
package calc_pkg;
    typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_RES = 2'd2} state_t;
    typedef enum logic [2:0] {KC_NONE, KC_DIGIT, KC_PLUS, KC_MINUS, KC_ENTER, KC_CLEAR} key_class_t;
    localparam logic [3:0] DIG_MINUS = 4'hA;
    localparam logic [3:0] DIG_BLANK = 4'hF;
    localparam logic [8:0] DIGIT_SC [10] = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025,
                                             9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046};
    function automatic logic [6:0] shift_digit(logic [6:0] x, logic [3:0] d);
        return (x % 7'd10) * 7'd10 + 7'(d);
    endfunction
    function automatic logic signed [8:0] calc_result(logic [6:0] a, logic [6:0] b, logic sub);
        logic signed [8:0] sa, sb;
        sa = $signed({2'b00, a});
        sb = $signed({2'b00, b});
        return sub ? sa - sb : sa + sb;
    endfunction
    function automatic logic [15:0] bcd_display(state_t s, logic [6:0] a, logic [6:0] b, logic sub);
        logic signed [8:0] r;
        logic [7:0] m;
        logic [7:0] at_ao, bt_bo;
        r = calc_result(a, b, sub);
        m = r[8] ? 8'(-r) : r[7:0];
        at_ao = {4'(a / 7'd10), 4'(a % 7'd10)};
        bt_bo = {4'(b / 7'd10), 4'(b % 7'd10)};
        return s == S_A ? {DIG_BLANK, DIG_BLANK, at_ao} :
               s == S_B ? {at_ao, bt_bo} :
               {r[8] ? DIG_MINUS : DIG_BLANK, 4'(m / 8'd100), 4'((m % 8'd100) / 8'd10), 4'(m % 8'd10)};
    endfunction
endpackage

// File: rtl/calc_entry_ctrl_if.sv
// calc_entry_ctrl_if: key event inputs and display/status outputs of the calculator controller.
interface calc_entry_ctrl_if;
    logic        key_valid;
    logic [8:0]  last_change;
    logic        key_held;
    logic [15:0] disp_digits;
    logic [1:0]  state;
    logic        op_sub;
    logic        result_valid;
    modport master (output key_valid, last_change, key_held,
                    input disp_digits, state, op_sub, result_valid);
    modport slave  (input key_valid, last_change, key_held,
                    output disp_digits, state, op_sub, result_valid);
endinterface

// File: rtl/calc_entry_ctrl_key_map.sv
// calc_key_map: combinational scan code to key class and digit value.
module calc_key_map
    import calc_pkg::*;
#(
    parameter logic [8:0] KEY_PLUS  = 9'h079,
    parameter logic [8:0] KEY_MINUS = 9'h07B,
    parameter logic [8:0] KEY_ENTER = 9'h05A,
    parameter logic [8:0] KEY_CLEAR = 9'h076
) (
    input  logic [8:0]  code,
    output key_class_t  kc,
    output logic [3:0]  digit
);
    always_comb begin
        kc = KC_NONE;
        digit = 4'd0;
        for (int i = 0; i < 10; i++)
            if (code == DIGIT_SC[i]) begin
                kc = KC_DIGIT;
                digit = 4'(i);
            end
        if (code == KEY_PLUS)  kc = KC_PLUS;
        if (code == KEY_MINUS) kc = KC_MINUS;
        if (code == KEY_ENTER) kc = KC_ENTER;
        if (code == KEY_CLEAR) kc = KC_CLEAR;
    end
endmodule

// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: two-operand decimal calculator entry FSM driving four BCD display digits.
// Define CALC_CHAIN_EN to let an op key in S_RES continue from an in-range result.
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter logic [8:0] KEY_PLUS  = 9'h079,
    parameter logic [8:0] KEY_MINUS = 9'h07B,
    parameter logic [8:0] KEY_ENTER = 9'h05A,
    parameter logic [8:0] KEY_CLEAR = 9'h076
) (
    input logic clk,
    input logic reset,
    calc_entry_ctrl_if.slave bus
);
    state_t      st, st_n;
    logic [6:0]  a, a_n, b, b_n;
    logic        sub, sub_n, rv, rv_n;
    logic [15:0] disp;
    logic [8:0]  trk_code;
    logic        trk_valid;
    key_class_t  kc;
    logic [3:0]  dv;
    logic        press, is_op;
    calc_key_map #(.KEY_PLUS(KEY_PLUS), .KEY_MINUS(KEY_MINUS), .KEY_ENTER(KEY_ENTER),
                   .KEY_CLEAR(KEY_CLEAR)) u_map (.code(bus.last_change), .kc(kc), .digit(dv));
    // A make of the key already held is a typematic repeat, not a press
    assign press = bus.key_valid & bus.key_held & !(trk_valid & bus.last_change == trk_code);
    assign is_op = kc == KC_PLUS || kc == KC_MINUS;
    always_comb begin
        st_n = st;
        a_n = a;
        b_n = b;
        sub_n = sub;
        rv_n = rv;
`ifdef CALC_CHAIN_EN
        begin : chain
            logic signed [8:0] r;
            r = calc_result(a, b, sub);
            if (press && st == S_RES && is_op && !r[8] && r[7:0] <= 8'd99) begin
                a_n = r[6:0];
                b_n = 7'd0;
                sub_n = kc == KC_MINUS;
                rv_n = 1'b0;
                st_n = S_B;
            end
        end
`endif
        if (press && kc == KC_CLEAR) begin
            st_n = S_A;
            a_n = 7'd0;
            b_n = 7'd0;
            sub_n = 1'b0;
            rv_n = 1'b0;
        end else if (press) begin
            case (st)
                S_A: begin
                    if (kc == KC_DIGIT) a_n = shift_digit(a, dv);
                    if (is_op) begin
                        sub_n = kc == KC_MINUS;
                        b_n = 7'd0;
                        st_n = S_B;
                    end
                end
                S_B: begin
                    if (kc == KC_DIGIT) b_n = shift_digit(b, dv);
                    if (is_op) sub_n = kc == KC_MINUS;
                    if (kc == KC_ENTER) begin
                        st_n = S_RES;
                        rv_n = 1'b1;
                    end
                end
                S_RES: begin
                    if (kc == KC_DIGIT) begin
                        a_n = 7'(dv);
                        b_n = 7'd0;
                        rv_n = 1'b0;
                        st_n = S_A;
                    end
                end
                default: st_n = S_A;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            st <= S_A;
            a <= 7'd0;
            b <= 7'd0;
            sub <= 1'b0;
            rv <= 1'b0;
            disp <= {DIG_BLANK, DIG_BLANK, 8'h00};
            trk_code <= 9'd0;
            trk_valid <= 1'b0;
        end else begin
            st <= st_n;
            a <= a_n;
            b <= b_n;
            sub <= sub_n;
            rv <= rv_n;
            disp <= bcd_display(st_n, a_n, b_n, sub_n);
            if (press) begin
                trk_code <= bus.last_change;
                trk_valid <= 1'b1;
            end else if (bus.key_valid && !bus.key_held && bus.last_change == trk_code) begin
                trk_valid <= 1'b0;
            end
        end
    end
    assign bus.disp_digits = disp;
    assign bus.state = st;
    assign bus.op_sub = sub;
    assign bus.result_valid = rv;
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb_calc_entry_ctrl: directed-vector bench for calc_entry_ctrl; status packed as {disp, state, op_sub, result_valid}.
module tb_calc_entry_ctrl;
    logic clk = 1'b0;
    logic reset;
    int vectors = 0;
    int miscompares = 0;
    localparam logic [8:0] SC [10] = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025,
                                       9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046};
    localparam logic [8:0] PLUS = 9'h079, MINUS = 9'h07B, ENTER = 9'h05A, ESC = 9'h076;
    always #5 clk = ~clk;
    calc_entry_ctrl_if bus ();
    calc_entry_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
    wire [19:0] obs = {bus.disp_digits, bus.state, bus.op_sub, bus.result_valid};

    task automatic ev(input logic [8:0] code, input logic held);
        @(posedge clk);
        #1;
        bus.key_valid = 1'b1;
        bus.last_change = code;
        bus.key_held = held;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
    endtask

    task automatic tap(input logic [8:0] code);
        ev(code, 1'b1);
        ev(code, 1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.key_valid = 1'b1;
        bus.last_change = SC[7];
        bus.key_held = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        bus.key_valid = 1'b0;
        vectors++;
        if (obs !== {16'hFF00, 2'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: got %h want %h", obs, {16'hFF00, 2'd0, 1'b0, 1'b0});
        end
        ev(SC[7], 1'b1);
        vectors++;
        if (obs !== {16'hFF07, 2'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_tracker: got %h want %h", obs, {16'hFF07, 2'd0, 1'b0, 1'b0});
        end
        ev(SC[7], 1'b0);
    endtask

    task automatic test_digits;
        tap(ESC);
        ev(SC[4], 1'b1);
        vectors++;
        if (obs !== {16'hFF04, 2'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL digit4: got %h want %h", obs, {16'hFF04, 2'd0, 1'b0, 1'b0});
        end
        ev(SC[4], 1'b0);
        ev(SC[2], 1'b1);
        vectors++;
        if (obs !== {16'hFF42, 2'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL digit42: got %h want %h", obs, {16'hFF42, 2'd0, 1'b0, 1'b0});
        end
        ev(SC[2], 1'b0);
    endtask

    task automatic test_add;
        tap(ENTER);
        vectors++;
        if (obs !== {16'hFF42, 2'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL enter_in_a: got %h want %h", obs, {16'hFF42, 2'd0, 1'b0, 1'b0});
        end
        tap(PLUS);
        tap(SC[7]);
        vectors++;
        if (obs !== {16'h4207, 2'd1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL add_sb: got %h want %h", obs, {16'h4207, 2'd1, 1'b0, 1'b0});
        end
        tap(ENTER);
        vectors++;
        if (obs !== {16'hF049, 2'd2, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL add_res: got %h want %h", obs, {16'hF049, 2'd2, 1'b0, 1'b1});
        end
        tap(ENTER);
        vectors++;
        if (obs !== {16'hF049, 2'd2, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL enter_in_res: got %h want %h", obs, {16'hF049, 2'd2, 1'b0, 1'b1});
        end
        tap(SC[3]);
        vectors++;
        if (obs !== {16'hFF03, 2'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL digit_after_res: got %h want %h", obs, {16'hFF03, 2'd0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_max_sum;
        tap(ESC);
        tap(SC[9]); tap(SC[9]); tap(PLUS); tap(SC[9]); tap(SC[9]);
        vectors++;
        if (obs !== {16'h9999, 2'd1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL max_sb: got %h want %h", obs, {16'h9999, 2'd1, 1'b0, 1'b0});
        end
        tap(ENTER);
        tap(PLUS);
        vectors++;
        if (obs !== {16'hF198, 2'd2, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL max_res: got %h want %h", obs, {16'hF198, 2'd2, 1'b0, 1'b1});
        end
    endtask

    task automatic test_sub;
        tap(ESC);
        tap(SC[1]); tap(SC[5]); tap(MINUS); tap(SC[9]);
        vectors++;
        if (obs !== {16'h1509, 2'd1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL sub_b9: got %h want %h", obs, {16'h1509, 2'd1, 1'b1, 1'b0});
        end
        tap(SC[9]);
        tap(ENTER);
        vectors++;
        if (obs !== {16'hA084, 2'd2, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL sub_res: got %h want %h", obs, {16'hA084, 2'd2, 1'b1, 1'b1});
        end
        tap(PLUS);
        vectors++;
        if (obs !== {16'hA084, 2'd2, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL neg_chain_ignored: got %h want %h", obs, {16'hA084, 2'd2, 1'b1, 1'b1});
        end
    endtask

    task automatic test_op_switch;
        tap(ESC);
        tap(SC[2]); tap(PLUS); tap(MINUS);
        vectors++;
        if (obs !== {16'h0200, 2'd1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL op_switch: got %h want %h", obs, {16'h0200, 2'd1, 1'b1, 1'b0});
        end
        tap(SC[9]); tap(ENTER);
        vectors++;
        if (obs !== {16'hA007, 2'd2, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL op_switch_res: got %h want %h", obs, {16'hA007, 2'd2, 1'b1, 1'b1});
        end
    endtask

    task automatic test_typematic;
        tap(ESC);
        ev(SC[5], 1'b1);
        for (int i = 0; i < 3; i++) ev(SC[5], 1'b1);
        vectors++;
        if (obs !== {16'hFF05, 2'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL typematic: got %h want %h", obs, {16'hFF05, 2'd0, 1'b0, 1'b0});
        end
        ev(SC[5], 1'b0);
        ev(SC[5], 1'b1);
        vectors++;
        if (obs !== {16'hFF55, 2'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL repress: got %h want %h", obs, {16'hFF55, 2'd0, 1'b0, 1'b0});
        end
        ev(SC[5], 1'b0);
    endtask

    task automatic test_clear;
        tap(ESC);
        tap(SC[1]); tap(SC[2]); tap(SC[3]);
        vectors++;
        if (obs !== {16'hFF23, 2'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL two_digits: got %h want %h", obs, {16'hFF23, 2'd0, 1'b0, 1'b0});
        end
        tap(MINUS); tap(SC[4]);
        vectors++;
        if (obs !== {16'h2304, 2'd1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL pre_clear: got %h want %h", obs, {16'h2304, 2'd1, 1'b1, 1'b0});
        end
        tap(ESC);
        vectors++;
        if (obs !== {16'hFF00, 2'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL clear: got %h want %h", obs, {16'hFF00, 2'd0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_unmapped;
        tap(SC[8]);
        ev(9'h01C, 1'b1);
        ev(9'h179, 1'b1);
        ev(9'h179, 1'b0);
        ev(9'h01C, 1'b0);
        vectors++;
        if (obs !== {16'hFF08, 2'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL unmapped: got %h want %h", obs, {16'hFF08, 2'd0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_chain;
        tap(ESC);
        tap(SC[6]); tap(SC[0]); tap(PLUS); tap(SC[3]); tap(SC[0]); tap(ENTER);
        vectors++;
        if (obs !== {16'hF090, 2'd2, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL chain_res1: got %h want %h", obs, {16'hF090, 2'd2, 1'b0, 1'b1});
        end
        tap(PLUS);
`ifdef CALC_CHAIN_EN
        vectors++;
        if (obs !== {16'h9000, 2'd1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL chain_op: got %h want %h", obs, {16'h9000, 2'd1, 1'b0, 1'b0});
        end
        tap(SC[5]); tap(ENTER);
        vectors++;
        if (obs !== {16'hF095, 2'd2, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL chain_res2: got %h want %h", obs, {16'hF095, 2'd2, 1'b0, 1'b1});
        end
`else
        vectors++;
        if (obs !== {16'hF090, 2'd2, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL chain_op_ignored: got %h want %h", obs, {16'hF090, 2'd2, 1'b0, 1'b1});
        end
        tap(SC[5]); tap(ENTER);
        vectors++;
        if (obs !== {16'hFF05, 2'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL chain_restart: got %h want %h", obs, {16'hFF05, 2'd0, 1'b0, 1'b0});
        end
`endif
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.last_change = 9'd0;
        bus.key_held = 1'b0;
        test_reset;
        test_digits;
        test_add;
        test_max_sum;
        test_sub;
        test_op_switch;
        test_typematic;
        test_clear;
        test_unmapped;
        test_chain;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/calc_entry_ctrl.md
Name: calc_entry_ctrl

Overview:
- Sequencing controller for the keyboard-driven two-operand decimal calculator.
- Consumes decoded PS/2 make/break events from KeyboardDecoder and decides which operand a digit key loads and which operation is applied.
- On Enter, computes the result and drives four BCD display digits to the SSD select/decoder path.
- Replaces the ad-hoc per-operand enable toggling with a single FSM owning operands, operator and display content.

Parameters:
- KEY_PLUS, 9'h079, scan code of '+' (keypad +)
- KEY_MINUS, 9'h07B, scan code of '-' (keypad -)
- KEY_ENTER, 9'h05A, scan code that triggers evaluation
- KEY_CLEAR, 9'h076, scan code (Esc) that clears everything

Ports:
- clk  input  1  system clock (100 MHz)
- reset  input  1  synchronous, active-high reset
- key_valid  input  1  one-cycle pulse per decoded make or break event
- last_change  input  9  scan code of the latest event
- key_held  input  1  key_down[last_change]; 1 = make, 0 = break
- disp_digits  output  16  four 4-bit display codes, [15:12] leftmost
- state  output  2  current FSM state
- op_sub  output  1  1 = subtraction selected
- result_valid  output  1  high while a computed result is displayed

Behaviour:
- One clock, synchronous active-high reset. Reset values: state=S_A, A=B=0, op_sub=0, result_valid=0, disp_digits={BLANK,BLANK,0,0}, held tracker cleared.
- Press event: key_valid & key_held & !(tracked_valid & last_change==tracked_code). On a press, store tracked_code=last_change and set tracked_valid.
- Break event: key_valid & !key_held & last_change==tracked_code clears tracked_valid. Typematic repeats of a held key therefore produce no press.
- Only press events act on the FSM. All register updates occur on the clock edge after the key_valid cycle. disp_digits/result_valid are registered, so latency is 1 cycle from key_valid.
- Digit load, operand X ∈ {A,B}: X <= (X mod 10)*10 + d. Only the last two digits are kept, range 0..99.
- S_A:
  - digit → load A.
  - KEY_PLUS/KEY_MINUS → set op_sub, clear B, go S_B.
  - Enter is ignored.
- S_B:
  - digit → load B.
  - KEY_PLUS/KEY_MINUS → update op_sub only; stay in S_B.
  - Enter → compute R, go S_RES, result_valid <= 1.
- S_RES:
  - digit → A <= d, B <= 0, result_valid <= 0, go S_A.
  - Op keys: see Optional Feature.
  - Enter is ignored.
- KEY_CLEAR in any state → same effect as reset, but the held tracker is kept.
- Result: R = A+B (0..198) or A−B (−99..99). Display magnitude as hundreds/tens/ones. Leftmost digit is MINUS if R<0, else BLANK.
- Leading zeros are shown (e.g. 7 displays as " 007").
- Display per state:
  - S_A: {BLANK,BLANK,A_tens,A_ones}
  - S_B: {A_tens,A_ones,B_tens,B_ones}
  - S_RES: {sign,hund,tens,ones}
- Unmapped scan codes are ignored but still tracked for repeat suppression.
- A key_valid pulse coinciding with reset is dropped.

Optional Feature:
- Macro CALC_CHAIN_EN.
- Defined: in S_RES, KEY_PLUS/KEY_MINUS with 0≤R≤99 → A<=R, B<=0, op_sub set, result_valid<=0, go S_B. If R>99 or R<0, the key is ignored.
- Undefined: op keys are ignored in S_RES.

Decomposition:
- Package calc_pkg:
  - state encoding S_A=2'd0, S_B=2'd1, S_RES=2'd2
  - key class enum KC_NONE/KC_DIGIT/KC_PLUS/KC_MINUS/KC_ENTER/KC_CLEAR
  - display codes DIG_MINUS=4'hA, DIG_BLANK=4'hF
  - the ten set-2 digit scan codes (0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46)
- Sub-module calc_key_map: combinational scan code → {key class, digit value}. Keeps the FSM free of code tables.

Test Plan:
- Reset, then press 4, 2 → disp_digits={F,F,4,2}, state=0, one cycle after each key_valid.
- 4,2,'+',7,Enter → S_B shows {4,2,0,7}; S_RES shows {F,0,4,9}; result_valid=1.
- 1,5,'-',9,9,Enter → {A,0,8,4} (−84); op_sub=1.
- Hold '5' with three typematic make events then break → A=5 only; next press of '5' → A=55.
- Type 1,2,3 → A=23. Esc mid-entry in S_B → full reset display, state=0.
- 6,0,'+',3,0,Enter,'+',5,Enter → with CALC_CHAIN_EN: 95 shown {F,0,9,5}. Without it: second '+' ignored, display stays {F,0,9,0}.
